// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Outputs are combinational from state, Instr, Zero and mem_ready; state advances on clk.
// Memory stalls hold FETCH/MEM until mem_ready; 16 stalled cycles lock the FSM in ERROR.
module multicycle_control (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IR_WrEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_RdEn,
  output logic        Mem_WrEn,
  output logic        lui,
  output logic        lb,
  output logic        sb,
  output logic        Instr_done,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [5:0] op;
  logic is_r, is_li, is_lui, is_addi, is_andi, is_ori;
  logic is_b, is_beq, is_bne, is_lb, is_lw, is_sb, is_sw;
  logic is_imm, is_load, is_store, is_mem, is_branch, is_valid;
  logic waiting, wait_last;

  // ALU controls shared between EXEC and MEM
  logic [3:0] alu_func_op;
  logic       bin_op;
  logic       rfb_op;

  assign op        = Instr[31:26];
  assign is_r      = (op == 6'b100000);
  assign is_li     = (op == 6'b111000);
  assign is_lui    = (op == 6'b111001);
  assign is_addi   = (op == 6'b110000);
  assign is_andi   = (op == 6'b110010);
  assign is_ori    = (op == 6'b110011);
  assign is_b      = (op == 6'b111111);
  assign is_beq    = (op == 6'b000000);
  assign is_bne    = (op == 6'b000001);
  assign is_lb     = (op == 6'b000011);
  assign is_sb     = (op == 6'b000111);
  assign is_lw     = (op == 6'b001111);
  assign is_sw     = (op == 6'b011111);

  assign is_imm    = is_li | is_lui | is_addi | is_andi | is_ori;
  assign is_load   = is_lb | is_lw;
  assign is_store  = is_sb | is_sw;
  assign is_mem    = is_load | is_store;
  assign is_branch = is_b | is_beq | is_bne;
  // An all-zero word decodes as beq but is treated as a nop
  assign is_valid  = (Instr != 32'd0) & (is_r | is_imm | is_mem | is_branch);

  // A wait cycle is a FETCH/MEM cycle with the memory not yet done
  assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wait_last = (wait_q == 4'hF);
  assign wait_d    = waiting ? (wait_q + 4'd1) : 4'd0;

  // Per-opcode ALU operation and operand selects
  always_comb begin
    alu_func_op = 4'b0000;
    if (is_r)                alu_func_op = Instr[3:0];
    else if (is_andi)        alu_func_op = 4'b0010;
    else if (is_ori)         alu_func_op = 4'b0011;
    else if (is_beq|is_bne)  alu_func_op = 4'b0001;
    bin_op = is_imm | is_mem;
    rfb_op = is_imm | is_mem | is_branch;
  end

  // Next-state and output decode; anything not asserted stays 0
  always_comb begin
    state_d       = state_q;
    IR_WrEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    lui           = 1'b0;
    lb            = 1'b0;
    sb            = 1'b0;
    Instr_done    = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_FETCH: begin
        Mem_RdEn = 1'b1;
        // Reset forces FETCH; keep the IR from loading while it is held
        IR_WrEn  = mem_ready & ~Reset;
        if (mem_ready)      state_d = S_DECODE;
        else if (wait_last) state_d = S_ERROR;
      end
      S_DECODE: begin
        if (is_valid) begin
          state_d = S_EXEC;
        end else begin
          PC_LdEn    = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        ALU_func    = alu_func_op;
        ALU_Bin_sel = bin_op;
        RF_B_sel    = rfb_op;
        lui         = is_lui;
        if (is_r || is_imm) begin
          state_d = S_WB;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          PC_sel     = is_b | (is_beq & Zero) | (is_bne & ~Zero);
          PC_LdEn    = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEM: begin
        ALU_func    = alu_func_op;
        ALU_Bin_sel = bin_op;
        RF_B_sel    = rfb_op;
        Mem_RdEn    = is_load;
        Mem_WrEn    = is_store;
        lb          = is_lb;
        sb          = is_sb;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            PC_LdEn    = 1'b1;
            Instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (wait_last) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = is_load;
        lb            = is_lb;
        lui           = is_lui;
        PC_LdEn       = 1'b1;
        Instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_ERROR: begin
        err     = 1'b1;
        state_d = S_ERROR;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and wait counter registers; reset drops straight back to FETCH
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

endmodule
